// File: rtl/vr_pkg.sv
// Shared types, constants and the LFSR step function for the valid/ready traffic generator.
package vr_pkg;

  typedef enum logic [1:0] {FIXED = 2'd0, RANDOM = 2'd1, BURST = 2'd2} vr_mode_e;
  typedef enum logic [1:0] {IDLE = 2'd0, GAP = 2'd1, DRIVE = 2'd2} gen_state_e;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int          BURST_LEN = 4;
  localparam int          BURST_W   = $clog2(BURST_LEN);

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/vr_lfsr16.sv
// 16-bit Galois LFSR: reloadable from a seed, advances one step per request.
module vr_lfsr16
  import vr_pkg::*;
#(
  parameter logic [15:0] RST_VAL = 16'h0011
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  input  logic        advance_i,
  output logic [15:0] value_o
);

  logic [15:0] value_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= RST_VAL;
    end else if (load_i) begin
      value_q <= seed_i;
    end else if (advance_i) begin
      value_q <= lfsr_step(value_q);
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/vr_traffic_gen.sv
// Valid/ready master traffic generator: counted runs of LFSR payloads separated by
// fixed, random or burst-shaped gaps, stalling cleanly under sink back-pressure.
module vr_traffic_gen
  import vr_pkg::*;
#(
  parameter int          DATA_W  = 8,
  parameter int          DELAY_W = 3,
  parameter int          COUNT_W = 16,
  parameter int unsigned SEED    = 17
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  input  logic [DELAY_W-1:0] fixed_delay_i,
  input  logic [DELAY_W-1:0] max_delay_i,
  input  logic [COUNT_W-1:0] num_xfers_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [DATA_W-1:0]  data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [COUNT_W-1:0] xfer_cnt_o
);

  localparam logic [15:0] SEED16 = 16'(SEED);

  gen_state_e         state_q;
  logic [1:0]         mode_q;
  logic [DELAY_W-1:0] fixed_q, max_q, gap_q;
  logic [COUNT_W-1:0] num_q, cnt_q, cnt_inc;
  logic [BURST_W-1:0] burst_q;
  logic               valid_q, busy_q, done_q;
  logic [15:0]        lfsr_val, lfsr_next;
  logic               lfsr_load, hs, grp_first;
  logic [DELAY_W-1:0] d_start, d_next;

  // Gap before a transfer, drawn from the LFSR value that transfer will carry.
  function automatic logic [DELAY_W-1:0] calc_gap(input logic [1:0]         m,
                                                   input logic [15:0]        l,
                                                   input logic               first,
                                                   input logic [DELAY_W-1:0] fd,
                                                   input logic [DELAY_W-1:0] md);
    logic [DELAY_W:0] r, div;
    r        = {1'b0, l[15 -: DELAY_W]};
    div      = {1'b0, md} + 1'b1;
    calc_gap = fd;
    if (m == RANDOM) calc_gap = DELAY_W'(r % div);
    else if (m == BURST) calc_gap = first ? fd : '0;
  endfunction

  assign lfsr_load = (state_q == IDLE) && start_i;
  assign hs        = valid_q && ready_i;
  assign lfsr_next = lfsr_step(lfsr_val);
  assign cnt_inc   = cnt_q + 1'b1;
  assign grp_first = (burst_q == BURST_W'(BURST_LEN - 1));
  assign d_start   = calc_gap(mode_i, SEED16, 1'b1, fixed_delay_i, max_delay_i);
  assign d_next    = calc_gap(mode_q, lfsr_next, grp_first, fixed_q, max_q);

  vr_lfsr16 #(.RST_VAL(SEED16)) u_lfsr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (lfsr_load),
    .seed_i   (SEED16),
    .advance_i(hs),
    .value_o  (lfsr_val)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mode_q  <= '0;
      fixed_q <= '0;
      max_q   <= '0;
      num_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cnt_q   <= '0;
            burst_q <= '0;
            mode_q  <= mode_i;
            fixed_q <= fixed_delay_i;
            max_q   <= max_delay_i;
            num_q   <= num_xfers_i;
            if (num_xfers_i == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q <= 1'b1;
              if (d_start != '0) begin
                state_q <= GAP;
                gap_q   <= d_start;
              end else begin
                state_q <= DRIVE;
                valid_q <= 1'b1;
              end
            end
          end
        end
        GAP: begin
          if (gap_q == DELAY_W'(1)) begin
            state_q <= DRIVE;
            valid_q <= 1'b1;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        DRIVE: begin
          if (ready_i) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == num_q) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              burst_q <= grp_first ? '0 : burst_q + 1'b1;
              if (d_next != '0) begin
                state_q <= GAP;
                gap_q   <= d_next;
                valid_q <= 1'b0;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = lfsr_val[DATA_W-1:0];
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign xfer_cnt_o = cnt_q;

endmodule
